// File: rtl/proc_driver.sv
`default_nettype none
// ============================================================================
// Module      : proc_driver
// Description : Initiator for the three-operand capture/op/valid processing
//               protocol. Takes one job (A, B, C) from an upstream valid/ready
//               port, drives start plus the shared operand bus in the cycles
//               the unit captures A, B and C, waits for the unit's valid pulse
//               with a bounded timeout, and holds the result downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_driver #(
    parameter int WIDTH   = 8,
    parameter int RWIDTH  = 8,
    parameter int TIMEOUT = 15   // legal range 2..255
) (
    input  logic              clock,
    input  logic              rst,
    // upstream job port
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    input  logic [WIDTH-1:0]  req_c,
    // processing unit side
    output logic              start,
    output logic [WIDTH-1:0]  data_out,
    input  logic              proc_valid,
    input  logic [RWIDTH-1:0] proc_result,
    // downstream response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RWIDTH-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_A   = 3'd1,
        S_SEND_B   = 3'd2,
        S_SEND_C   = 3'd3,
        S_WAIT_RES = 3'd4,
        S_HOLD_RSP = 3'd5
    } state_t;

    // The wait counter is 8 bits because TIMEOUT tops out at 255.
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    state_t              state_q,       state_d;
    logic [WIDTH-1:0]    a_q,           a_d;
    logic [WIDTH-1:0]    b_q,           b_d;
    logic [WIDTH-1:0]    c_q,           c_d;
    logic [7:0]          cnt_q,         cnt_d;
    logic [RWIDTH-1:0]   rsp_data_q,    rsp_data_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    // State, operand, counter and response registers; async reset to IDLE.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            cnt_q         <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            c_q           <= c_d;
            cnt_q         <= cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state logic: sequence A/B/C onto the bus, then wait for the result
    // or the timeout, then hold the response until downstream takes it.
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        cnt_d         = cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    c_d     = req_c;
                    state_d = S_SEND_A;
                end
            end
            S_SEND_A: state_d = S_SEND_B;
            S_SEND_B: state_d = S_SEND_C;
            S_SEND_C: begin
                // First WAIT_RES cycle counts as cycle 1.
                cnt_d   = 8'd1;
                state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                // A valid result takes priority over an expiring timeout.
                if (proc_valid) begin
                    rsp_data_d    = proc_result;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_HOLD_RSP;
                end else if (cnt_q == C_TIMEOUT) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_HOLD_RSP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode; reset forces IDLE so outputs follow immediately.
    always_comb begin
        req_ready = 1'b0;
        start     = 1'b0;
        data_out  = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_SEND_A: begin
                start    = 1'b1;
                data_out = a_q;
            end
            S_SEND_B:   data_out  = b_q;
            S_SEND_C:   data_out  = c_q;
            S_WAIT_RES: data_out  = '0;
            S_HOLD_RSP: rsp_valid = 1'b1;
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_driver
// Description : Self-checking bench for proc_driver. Expected responses are
//               queued when the unit-model stimulus is decided and popped when
//               the driver presents rsp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_driver;

    localparam int WIDTH   = 8;
    localparam int RWIDTH  = 8;
    localparam int TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              rst   = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [WIDTH-1:0]  req_a = '0, req_b = '0, req_c = '0;
    logic              start;
    logic [WIDTH-1:0]  data_out;
    logic              proc_valid = 1'b0;
    logic [RWIDTH-1:0] proc_result = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [RWIDTH-1:0] rsp_data;
    logic              rsp_timeout;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // Expected response: {timeout flag, data}
    logic [RWIDTH:0] exp_q[$];

    proc_driver #(.WIDTH(WIDTH), .RWIDTH(RWIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_c       (req_c),
        .start       (start),
        .data_out    (data_out),
        .proc_valid  (proc_valid),
        .proc_result (proc_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (req_ready !== 1'b1 || start !== 1'b0 || data_out !== 8'h00 ||
            rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 8'h00 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b st=%b do=%h rv=%b busy=%b rd=%h to=%b, want 1 0 00 0 0 00 0",
                     req_ready, start, data_out, rsp_valid, busy, rsp_data, rsp_timeout);
        end
        rst = 1'b0;
        tick();
    endtask

    // One full job. vat = WAIT_RES cycle (1-based) in which the unit model
    // pulses proc_valid, 0 = never. bp = cycles of rsp_ready backpressure.
    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input int vat, input logic [7:0] res, input int bp,
                           input bit stray, input string name);
        int cyc;
        int exp_lat;
        int guard;
        logic [RWIDTH:0] exp;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_wait: req_ready=%b, want 1", name, req_ready);
        end
        req_valid = 1'b1; req_a = a; req_b = b; req_c = c;
        tick();                                   // cycle T: SEND_A
        req_valid = 1'b0; req_a = 8'hFF; req_b = 8'hFF; req_c = 8'hFF;
        checks++;
        if (start !== 1'b1 || data_out !== a || busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_send_a: st=%b do=%h busy=%b rdy=%b, want 1 %h 1 0", name, start, data_out, busy, req_ready, a);
        end
        tick();                                   // T+1: SEND_B
        checks++;
        if (start !== 1'b0 || data_out !== b || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_send_b: st=%b do=%h busy=%b, want 0 %h 1", name, start, data_out, busy, b);
        end
        if (stray) begin proc_valid = 1'b1; proc_result = 8'hEE; end
        tick();                                   // T+2: SEND_C
        proc_valid = 1'b0;
        checks++;
        if (start !== 1'b0 || data_out !== c || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_send_c: st=%b do=%h busy=%b, want 0 %h 1", name, start, data_out, busy, c);
        end
        if (vat > 0 && vat <= TIMEOUT) begin
            exp_q.push_back({1'b0, res});
            exp_lat = 3 + vat;
        end else begin
            exp_q.push_back({1'b1, 8'h00});
            exp_lat = 3 + TIMEOUT;
        end
        cyc = 2;
        forever begin
            tick();
            cyc++;
            proc_valid = 1'b0;
            if (rsp_valid === 1'b1 || cyc > 40) break;
            if (data_out !== 8'h00 || busy !== 1'b1 || start !== 1'b0) begin
                checks++; errors++;
                $display("FAIL %s_wait_res: cyc=%0d do=%h busy=%b st=%b, want 00 1 0", name, cyc, data_out, busy, start);
            end
            if (cyc - 2 == vat) begin proc_valid = 1'b1; proc_result = res; end
        end
        checks++;
        if (cyc != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: rsp_valid at T+%0d, want T+%0d", name, cyc, exp_lat);
        end
        if (exp_q.size() == 0) exp = '0;
        else exp = exp_q.pop_front();
        checks++;
        if (rsp_data !== exp[RWIDTH-1:0] || rsp_timeout !== exp[RWIDTH] || req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_response: data=%h to=%b rdy=%b busy=%b, want %h %b 0 1",
                     name, rsp_data, rsp_timeout, req_ready, busy, exp[RWIDTH-1:0], exp[RWIDTH]);
        end
        for (int i = 0; i < bp; i++) begin
            if (stray && i == 0) begin proc_valid = 1'b1; proc_result = 8'hEE; end
            tick();
            proc_valid = 1'b0;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp[RWIDTH-1:0] ||
                rsp_timeout !== exp[RWIDTH] || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold%0d: rv=%b data=%h to=%b rdy=%b, want 1 %h %b 0",
                         name, i, rsp_valid, rsp_data, rsp_timeout, req_ready, exp[RWIDTH-1:0], exp[RWIDTH]);
            end
        end
        // Hand-off edge; a waiting job must not be accepted on this same edge.
        rsp_ready = 1'b1; req_valid = 1'b1;
        tick();
        rsp_ready = 1'b0; req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("FAIL %s_handoff: rv=%b rdy=%b busy=%b st=%b, want 0 1 0 0", name, rsp_valid, req_ready, busy, start);
        end
    endtask

    task automatic test_nominal();
        run_job(8'h12, 8'h34, 8'h56, 2, 8'h9A, 0, 1'b0, "nominal");
    endtask

    task automatic test_backpressure();
        run_job(8'h12, 8'h34, 8'h56, 2, 8'h9A, 7, 1'b0, "backpressure");
    endtask

    task automatic test_timeout();
        run_job(8'hA5, 8'h5A, 8'hC3, 0, 8'h00, 1, 1'b0, "timeout");
    endtask

    task automatic test_boundary();
        run_job(8'h0F, 8'hF0, 8'h77, TIMEOUT, 8'h3C, 1, 1'b0, "boundary");
    endtask

    task automatic test_stray_valid();
        run_job(8'h21, 8'h43, 8'h65, 3, 8'h87, 2, 1'b1, "stray");
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            run_job(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1 + j * 4, r, j, 1'b0, "b2b");
        end
    endtask

    task automatic test_async_reset();
        req_valid = 1'b1; req_a = 8'hAA; req_b = 8'hBB; req_c = 8'hCC;
        tick();                                   // SEND_A
        req_valid = 1'b0;
        tick();                                   // SEND_B
        checks++;
        if (data_out !== 8'hBB || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: do=%h busy=%b, want bb 1", data_out, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (start !== 1'b0 || data_out !== 8'h00 || busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: st=%b do=%h busy=%b rdy=%b rv=%b, want 0 00 0 1 0",
                     start, data_out, busy, req_ready, rsp_valid);
        end
        tick();
        #2 rst = 1'b0;
        tick();
        run_job(8'h01, 8'h02, 8'h03, 2, 8'h06, 0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_boundary();
        test_stray_valid();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/proc_driver.md
Name: proc_driver

Overview:
- Initiator side of the three-operand capture/op/valid processing protocol.
- Accepts one job (operands A, B, C) from an upstream valid/ready port and drives `start` plus a shared serial operand bus in the exact cycles the processing unit captures A, B and C.
- Waits for the unit's `valid` pulse, captures the result with a bounded timeout, and holds it on a downstream valid/ready response port.

Parameters:
- WIDTH, 8: width of each operand and of the shared operand bus.
- RWIDTH, 8: width of the processing unit's result.
- TIMEOUT, 15: maximum WAIT_RES cycles allowed for `proc_valid` before the job is aborted. Legal range 2..255.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  upstream job present.
- req_ready  out  1  block can accept a job.
- req_a  in  WIDTH  operand A; sampled on request handshake.
- req_b  in  WIDTH  operand B; sampled on request handshake.
- req_c  in  WIDTH  operand C; sampled on request handshake.
- start  out  1  start strobe to the processing unit.
- data_out  out  WIDTH  shared operand bus to the processing unit.
- proc_valid  in  1  result-valid pulse from the processing unit.
- proc_result  in  RWIDTH  result from the processing unit.
- rsp_valid  out  1  response held for downstream.
- rsp_ready  in  1  downstream accepts response.
- rsp_data  out  RWIDTH  captured result; 0 on timeout.
- rsp_timeout  out  1  response is a timeout abort.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: clock and rst only; reset is asynchronous and active-high.
  - While rst is high: state = IDLE, operand registers = 0, wait counter = 0, rsp_data = 0, rsp_timeout = 0.
  - All outputs take IDLE values immediately, without waiting for a clock edge: req_ready = 1, start = 0, data_out = 0, rsp_valid = 0, busy = 0.
- Reset asserted mid-job aborts the job with no response. The processing unit is expected to be reset in the same domain.
- State machine, Moore outputs decoded from state:
  - IDLE: req_ready = 1.
    - req_valid = 1 at a clock edge: latch req_a/b/c, go to SEND_A.
  - SEND_A: start = 1, data_out = A. Next state SEND_B.
  - SEND_B: data_out = B. Next state SEND_C.
  - SEND_C: data_out = C. Next state WAIT_RES; counter cleared to 1.
  - WAIT_RES: data_out = 0.
    - Each cycle without proc_valid: counter increments.
    - proc_valid = 1: latch proc_result into rsp_data, rsp_timeout = 0, go to HOLD_RSP.
    - Otherwise, counter == TIMEOUT: rsp_data = 0, rsp_timeout = 1, go to HOLD_RSP.
    - proc_valid and counter == TIMEOUT in the same cycle: the valid result wins.
  - HOLD_RSP: rsp_valid = 1.
    - rsp_data and rsp_timeout stay stable until rsp_ready = 1 at a clock edge, then go to IDLE.
    - rsp_ready has no combinational path to any output.
- Protocol timing, with SEND_A as cycle T:
  - The unit captures A at T, B at T+1, C at T+2 and runs op at T+3.
  - A compliant unit pulses proc_valid at T+4, which is the second WAIT_RES cycle. The nominal response appears as rsp_valid at T+5.
- proc_valid outside WAIT_RES is ignored: no state change, no latch.
- req_ready is 0 outside IDLE. No job is accepted in the same cycle a response is handed off; minimum job spacing is 6 cycles.
- Unused encodings of the 3-bit state register return to IDLE on the next edge.
- Widths: proc_result is captured unmodified; no sign or width conversion.

Test Plan:
- Nominal: A=0x12, B=0x34, C=0x56; unit model answers 0x9A at T+4 -> start high only at T; data_out = 0x12, 0x34, 0x56 at T..T+2; rsp_valid at T+5 with rsp_data = 0x9A, rsp_timeout = 0; busy high T..T+5.
- Backpressure: rsp_ready held 0 for 7 cycles after rsp_valid -> rsp_data = 0x9A stable, req_ready = 0 throughout; response accepted on the first rsp_ready = 1 edge; IDLE next cycle.
- Timeout: unit never raises proc_valid, TIMEOUT = 15 -> after 15 WAIT_RES cycles, rsp_valid = 1, rsp_timeout = 1, rsp_data = 0.
- Boundary: proc_valid arrives in the same cycle counter == TIMEOUT with result 0x3C -> rsp_timeout = 0, rsp_data = 0x3C.
- Stray valid: proc_valid pulsed during SEND_B and again during HOLD_RSP -> no state change; rsp_data keeps the in-flight result.
- Async reset: assert rst during SEND_B without a clock edge -> start = 0, data_out = 0, busy = 0, req_ready = 1 immediately. After deassert, a new job A=0x01, B=0x02, C=0x03 completes normally.
